// File: rtl/booth_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : booth_dot_sequencer
// Purpose  : Buffers signed 8-bit operand pairs in a small FIFO, issues them
//            one at a time to a sequential Booth multiplier, accumulates the
//            returned 16-bit products into a signed dot-product and presents
//            each finished vector on a valid/ready result port.
// Ports    : clock, reset (async, active-low)
//            in_valid/in_ready/in_x/in_y/in_last  - operand pair input
//            mul_start/mul_x/mul_y                - issue to multiplier
//            mul_valid/mul_z                      - product return
//            out_valid/out_ready/out_acc/out_count/out_ovf - result port
//            busy                                 - FSM active or FIFO holds data
// Revision : 1.0 - initial release
// ============================================================================
module booth_dot_sequencer #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic             mul_valid,
  input  logic [15:0]      mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf,
  output logic             busy
);

  localparam int                  c_ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);
  localparam logic [c_ADDR_W:0]   c_OCC_ONE = (c_ADDR_W + 1)'(1);
  localparam logic [c_ADDR_W:0]   c_OCC_FULL = (c_ADDR_W + 1)'(DEPTH);
  localparam logic [LEN_W-1:0]    c_CNT_ONE = LEN_W'(1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
    end
    if (ACC_W < 16) begin : g_bad_acc_w
      $error("ACC_W must be at least 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FIFO storage: {last, x, y}
  logic [16:0]         r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_occ;
  logic                r_full;

  state_t                  r_state;
  logic                    r_last;
  logic [7:0]              r_mul_x;
  logic [7:0]              r_mul_y;
  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_count;
  logic                    r_ovf;

  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [16:0]             w_head;
  logic [c_ADDR_W:0]       w_occ_next;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_add_ovf;

  assign w_empty = (r_occ == '0);
  // Acceptance looks only at the registered full flag, so a full FIFO refuses
  // a push even in a cycle where the head is being popped.
  assign w_push  = in_valid && !r_full;
  assign w_head  = r_mem[r_rd_ptr];
  // The head is consumed when IDLE launches a pair, or when WAIT chains
  // straight into the next pair of the same vector.
  assign w_pop   = !w_empty &&
                   ((r_state == S_IDLE) ||
                    ((r_state == S_WAIT) && mul_valid && !r_last));

  always_comb begin
    w_occ_next = r_occ;
    if (w_push && !w_pop) begin
      w_occ_next = r_occ + c_OCC_ONE;
    end else if (!w_push && w_pop) begin
      w_occ_next = r_occ - c_OCC_ONE;
    end
  end

  assign w_prod_ext = ACC_W'($signed(mul_z));
  assign w_sum      = r_acc + w_prod_ext;
  // Signed overflow: both addends share a sign that the result does not.
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  // Storage is not reset; only the pointers/occupancy define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_last, in_x, in_y};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_state  <= S_IDLE;
      r_last   <= 1'b0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_occ  <= w_occ_next;
      r_full <= (w_occ_next == c_OCC_FULL);

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_last  <= w_head[16];
            r_mul_x <= w_head[15:8];
            r_mul_y <= w_head[7:0];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_valid) begin
            r_acc   <= w_sum;
            r_count <= r_count + c_CNT_ONE;
            r_ovf   <= r_ovf | w_add_ovf;
            if (r_last) begin
              r_state <= S_DONE;
            end else if (!w_empty) begin
              // Operands change only here, after the product has returned.
              r_last  <= w_head[16];
              r_mul_x <= w_head[15:8];
              r_mul_y <= w_head[7:0];
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = !r_full;
  assign mul_start = (r_state == S_ISSUE);
  assign mul_x     = r_mul_x;
  assign mul_y     = r_mul_y;
  assign out_valid = (r_state == S_DONE);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_booth_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_dot_sequencer
// Purpose  : Scoreboard bench for booth_dot_sequencer. Two instances (ACC_W=24
//            and ACC_W=16) share all stimulus and one behavioural 8-cycle
//            multiplier; expected results are queued when a vector is issued
//            and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_dot_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        mul_valid = 1'b0;
  logic [15:0] mul_z = '0;

  logic        in_ready, mul_start, out_valid, out_ovf, busy;
  logic [7:0]  mul_x, mul_y, out_count;
  logic [23:0] out_acc;

  logic        b_in_ready, b_mul_start, b_out_valid, b_out_ovf, b_busy;
  logic [7:0]  b_mul_x, b_mul_y, b_out_count;
  logic [15:0] b_out_acc;

  booth_dot_sequencer #(.DEPTH(4), .ACC_W(24), .LEN_W(8)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .busy(busy)
  );

  booth_dot_sequencer #(.DEPTH(4), .ACC_W(16), .LEN_W(8)) u_dut16 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .mul_start(b_mul_start), .mul_x(b_mul_x), .mul_y(b_mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
    .out_count(b_out_count), .out_ovf(b_out_ovf), .busy(b_busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int acc24;
    int acc16;
    int cnt;
    int ovf24;
    int ovf16;
  } exp_t;
  exp_t sb[$];

  // Behavioural multiplier: samples start when idle, runs 8 cycles, returns
  // the product with a one-cycle valid in the 9th cycle after the start.
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_x = '0;
  logic [7:0] m_y = '0;
  always @(negedge clock) begin
    int p;
    if (!reset) begin
      m_busy    = 1'b0;
      mul_valid = 1'b0;
      mul_z     = '0;
    end else begin
      mul_valid = 1'b0;
      if (m_busy) begin
        check("mul_xy_stable", {mul_x, mul_y}, {m_x, m_y});
        m_cnt++;
        if (m_cnt == 9) begin
          p         = $signed(m_x) * $signed(m_y);
          mul_z     = p[15:0];
          mul_valid = 1'b1;
          m_busy    = 1'b0;
        end
      end else if (mul_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_x    = mul_x;
        m_y    = mul_y;
      end
    end
  end

  // Monitor
  int          n_start = 0;
  int          last_start = 0;
  int          hs_cyc = 0;
  logic        expect_gap = 1'b0;
  logic        saw_full = 1'b0;
  logic        seen = 1'b0;
  logic [23:0] hold_acc;
  logic [7:0]  hold_cnt;
  always begin
    exp_t e;
    @(negedge clock);
    #2;
    if (!reset) begin
      seen = 1'b0;
    end else begin
      if (mul_start) begin
        n_start++;
        last_start = cyc;
        check("no_issue_in_done", out_valid, 0);
        if (expect_gap) begin
          check("issue_after_handshake", cyc - hs_cyc, 2);
          expect_gap = 1'b0;
        end
      end
      if (!in_ready) saw_full = 1'b1;
      if (out_valid) begin
        if (!seen) begin
          seen     = 1'b1;
          hold_acc = out_acc;
          hold_cnt = out_count;
          check("latency", cyc - last_start, 10);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got acc %0d, expected no result", $signed(out_acc));
          end else begin
            e = sb.pop_front();
            check("acc24", int'($signed(out_acc)), e.acc24);
            check("count24", out_count, e.cnt);
            check("ovf24", out_ovf, e.ovf24);
            check("valid16", b_out_valid, 1);
            check("acc16", int'($signed(b_out_acc)), e.acc16);
            check("count16", b_out_count, e.cnt);
            check("ovf16", b_out_ovf, e.ovf16);
          end
        end else begin
          check("acc_hold", out_acc, hold_acc);
          check("count_hold", out_count, hold_cnt);
        end
        if (out_ready) begin
          seen   = 1'b0;
          hs_cyc = cyc;
        end
      end
    end
  end

  task automatic sb_push(input int a24, input int a16, input int c, input int o24, input int o16);
    exp_t e;
    e.acc24 = a24; e.acc16 = a16; e.cnt = c; e.ovf24 = o24; e.ovf16 = o16;
    sb.push_back(e);
  endtask

  // Called and returning on a falling edge.
  task automatic push(input int x, input int y, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x[7:0];
    in_y     = y[7:0];
    in_last  = last;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check("push_timeout", n, 0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy || out_valid) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_time", n < 1000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_xy"}, {mul_x, mul_y}, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_acc"}, out_acc, 0);
    check({tag, "_out_count"}, out_count, 0);
    check({tag, "_out_ovf"}, out_ovf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_b_state"}, {b_in_ready, b_busy, b_out_valid}, 3'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single pair
    n_start = 0;
    sb_push(-12, -12, 1, 0, 0);
    push(3, -4, 1'b1);
    wait_done();
    check("single_start_pulses", n_start, 1);

    // Extreme operand vector
    sb_push(16222, 16222, 4, 0, 0);
    push(127, 127, 1'b0);
    push(-128, -128, 1'b0);
    push(-128, 127, 1'b0);
    push(5, -7, 1'b1);
    wait_done();

    // Six back-to-back pairs overfill the FIFO
    saw_full = 1'b0;
    sb_push(29, 29, 6, 0, 0);
    push(1, 2, 1'b0);
    push(3, 4, 1'b0);
    push(-5, 6, 1'b0);
    push(7, -8, 1'b0);
    push(10, 10, 1'b0);
    push(-1, -1, 1'b1);
    wait_done();
    check("in_ready_low_when_full", saw_full, 1);

    // Result stalled 20 cycles with a pair queued behind it
    begin
      int n = 0;
      out_ready = 1'b0;
      sb_push(26, 26, 2, 0, 0);
      push(2, 3, 1'b0);
      push(4, 5, 1'b1);
      while (!out_valid && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("stall_result_seen", out_valid, 1);
      sb_push(-9, -9, 1, 0, 0);
      push(-3, 3, 1'b1);
      repeat (20) @(negedge clock);
      check("stall_still_valid", out_valid, 1);
      expect_gap = 1'b1;
      out_ready  = 1'b1;
      wait_done();
    end

    // Overflow in the 16-bit instance, then a clean vector
    sb_push(48387, -17149, 3, 0, 1);
    push(127, 127, 1'b0);
    push(127, 127, 1'b0);
    push(127, 127, 1'b1);
    wait_done();
    sb_push(1, 1, 1, 0, 0);
    push(1, 1, 1'b1);
    wait_done();

    // Reset during WAIT with a further pair queued
    push(9, 9, 1'b1);
    push(1, 1, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_busy", busy, 0);
    sb_push(4, 4, 1, 0, 0);
    push(2, 2, 1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_dot_sequencer.md
# booth_dot_sequencer

Upstream operand feeder and downstream accumulator for the 8-bit sequential Booth multiplier. It buffers signed operand pairs in a small FIFO and issues them one at a time to the multiplier through its start/X/Y interface. It sums the returned 16-bit products into a signed dot-product accumulator and presents each completed vector result on a valid/ready output port.

## Interface
- DEPTH, 4: operand FIFO entries; must be a power of 2, at least 2.
- ACC_W, 24: accumulator width in bits; must be at least 16.
- LEN_W, 8: width of the pair counter.
- clock  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept a pair; equals !full.
- in_x  in  8  signed multiplicand.
- in_y  in  8  signed multiplier.
- in_last  in  1  this pair is the final pair of a vector.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  8  multiplicand to the multiplier; held stable until the next issue.
- mul_y  out  8  multiplier operand to the multiplier; held stable until the next issue.
- mul_valid  in  1  one-cycle product-valid pulse from the multiplier.
- mul_z  in  16  signed product; meaningful only while mul_valid=1.
- out_valid  out  1  dot-product result available.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  signed accumulated sum.
- out_count  out  LEN_W  number of pairs in the vector (mod 2^LEN_W).
- out_ovf  out  1  sticky flag: signed overflow occurred in the vector.
- busy  out  1  asserted when state != IDLE or the FIFO is non-empty.

## Operation
- FIFO storage: each entry holds {in_last, in_x, in_y}.
- Push: occurs when in_valid && in_ready.
- Pop: occurs when the FSM latches the head entry (see below).
- in_ready derives from the registered full flag only. When the FIFO is full, a push in the same cycle as a pop is refused.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If the FIFO is non-empty: load mul_x, mul_y and the last-flag register from the head entry, pop, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mul_start=1 for this cycle only (mul_start = state==ISSUE).
  - Always go to WAIT.
- WAIT:
  - Without mul_valid: stay in WAIT.
  - On mul_valid: acc <= acc + sext(mul_z) and count <= count + 1.
  - Set ovf if the ACC_W-bit signed add overflows; acc wraps two's-complement.
  - Next state:
    - last flag set: go to DONE.
    - last flag clear and FIFO non-empty: load and pop the next head, go to ISSUE directly (no IDLE hop).
    - otherwise: go to IDLE.
- DONE:
  - out_valid=1; out_acc, out_count and out_ovf are held stable.
  - On out_valid && out_ready: clear acc, count and ovf, go to IDLE.
  - The FIFO keeps accepting pushes while in DONE.
- mul_valid is ignored in IDLE, ISSUE and DONE.
- Multiplier contract:
  - The multiplier samples start only when it is idle.
  - It reads X and Y bits throughout the operation, so mul_x and mul_y must not change between ISSUE and the mul_valid pulse.

## Timing
- Reset values: in_ready=1, mul_start=0, mul_x=0, mul_y=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0, busy=0. FIFO is empty, FSM is in IDLE.
- A push in cycle t is visible to IDLE in cycle t+1; ISSUE occurs in t+2.
- With ISSUE in cycle c:
  - The multiplier runs during c+1..c+8.
  - mul_valid is seen in c+9, where the accumulate happens.
  - The next ISSUE is in c+10, or out_valid rises in c+10.
  - Sustained throughput is 10 cycles per pair.
- The result handshake in cycle d puts the FSM in IDLE at d+1. The earliest next ISSUE is d+2.
- Reset asserted mid-operation: all state returns to reset values immediately, and FIFO contents are discarded. The multiplier shares the same reset.
- count wraps at 2^LEN_W and is not flagged.

## Test plan
- Single pair (3, -4), last=1:
  - Exactly one mul_start pulse.
  - out_valid rises 10 cycles after ISSUE with out_acc=-12, out_count=1, out_ovf=0.
- Vector (127,127), (-128,-128), (-128,127), (5,-7), last on the fourth pair:
  - out_acc=16222, out_count=4.
  - mul_x and mul_y stay stable through each WAIT.
- Six pairs pushed back-to-back with DEPTH=4:
  - in_ready deasserts while the FIFO is full.
  - No pair is lost or duplicated; the sum matches the reference model.
- out_ready held low for 20 cycles in DONE:
  - out_valid and out_acc remain stable.
  - Pairs pushed meanwhile are not issued until the cycle after the handshake.
- ACC_W=16 with vector (127,127) ×3:
  - out_acc=-17149, out_ovf=1.
  - After the handshake, the next vector starts with acc=0 and ovf=0.
- Reset pulsed during WAIT:
  - All outputs return to reset values and in_ready=1.
  - A following single pair (2,2) yields out_acc=4.
